// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the debug OCI memory arbiter.
package debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_JTAG = 1'b1
    } grant_t;

    localparam int JDO_W         = 38;
    localparam int JDO_RDEN_BIT  = 17;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;

endpackage

// File: rtl/debug_ocimem_arbiter_jcmd.sv
// JTAG memory command decode: address register, one-entry pending slot, busy and overrun flags.
module debug_ocimem_jcmd
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              jtag_grant,
    input  logic              jtag_done,
    output logic [ADDR_W-1:0] jaddr,
    output logic              jtag_req,
    output logic              jtag_write,
    output logic [31:0]       jtag_wdata,
    output logic              mon_load,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    logic any_strobe;
    logic accept;
    logic unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign accept     = any_strobe & ~jtag_busy;
    assign mon_load   = accept & take_action_ocimem_b;
    assign unused_jdo = ^jdo;

    // Accept only happens while idle, so it never coincides with a grant or completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr        <= '0;
            jtag_req     <= 1'b0;
            jtag_write   <= 1'b0;
            jtag_wdata   <= '0;
            jtag_busy    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            if (any_strobe && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end
            if (jtag_grant) begin
                jtag_req <= 1'b0;
            end
            if (jtag_done) begin
                jtag_busy <= 1'b0;
                jaddr     <= jaddr + ADDR_W'(1);
            end
            if (accept) begin
                if (take_action_ocimem_a) begin
                    jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_RDEN_BIT]) begin
                        jtag_req   <= 1'b1;
                        jtag_busy  <= 1'b1;
                        jtag_write <= 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    jtag_req   <= 1'b1;
                    jtag_busy  <= 1'b1;
                    jtag_write <= 1'b0;
                end else begin
                    jtag_req   <= 1'b1;
                    jtag_busy  <= 1'b1;
                    jtag_write <= 1'b1;
                    jtag_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                end
            end
        end
    end

endmodule

// File: rtl/debug_ocimem_arbiter.sv
// Round-robin arbiter between JTAG debug commands and the CPU Avalon slave for the OCI RAM.
// Optional DEBUG_OCIMEM_WRPROT_EN adds debugack, which gates CPU writes to the RAM.
module debug_ocimem_arbiter
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef DEBUG_OCIMEM_WRPROT_EN
    input  logic              debugack,
`endif
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    state_t              state, next_state;
    grant_t              grant, next_grant, last_grant;
    logic                start;
    logic                op_write;
    logic                cpu_req;
    logic                cpu_wr_ok;
    logic                jtag_req, jtag_write, jtag_grant, jtag_done, mon_load;
    logic [ADDR_W-1:0]   jaddr;
    logic [DATA_W-1:0]   jtag_wdata;
    logic [DATA_W-1:0]   readdata_q;

    assign cpu_req = avs_read | avs_write;

`ifdef DEBUG_OCIMEM_WRPROT_EN
    assign cpu_wr_ok = debugack;
`else
    assign cpu_wr_ok = 1'b1;
`endif

    debug_ocimem_jcmd #(.ADDR_W(ADDR_W)) u_jcmd (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jtag_grant              (jtag_grant),
        .jtag_done               (jtag_done),
        .jaddr                   (jaddr),
        .jtag_req                (jtag_req),
        .jtag_write              (jtag_write),
        .jtag_wdata              (jtag_wdata),
        .mon_load                (mon_load),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    // last_grant starts at JTAG so the CPU wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= GNT_JTAG;
            last_grant <= GNT_JTAG;
        end else begin
            state <= next_state;
            grant <= next_grant;
            if (start) begin
                last_grant <= next_grant;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_grant = grant;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || jtag_req) begin
                    start      = 1'b1;
                    next_state = ACCESS;
                    if (cpu_req && jtag_req) begin
                        next_grant = (last_grant == GNT_CPU) ? GNT_JTAG : GNT_CPU;
                    end else if (cpu_req) begin
                        next_grant = GNT_CPU;
                    end else begin
                        next_grant = GNT_JTAG;
                    end
                end
            end
            ACCESS:  next_state = op_write ? IDLE : RD_WAIT;
            RD_WAIT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        jtag_grant      = start && (next_grant == GNT_JTAG);
        jtag_done       = (grant == GNT_JTAG) &&
                          (((state == ACCESS) && op_write) || (state == RD_WAIT));
        avs_waitrequest = !((grant == GNT_CPU) &&
                            (((state == ACCESS) && op_write) || (state == RD_WAIT)));
        avs_readdata    = ((state == RD_WAIT) && (grant == GNT_CPU)) ? ram_rdata : readdata_q;
    end

    // RAM controls are registered at grant so ram_addr holds its value between accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_write   <= 1'b0;
            ram_addr   <= '0;
            ram_wren   <= 1'b0;
            ram_byteen <= '0;
            ram_wdata  <= '0;
            readdata_q <= '0;
            MonDReg    <= '0;
        end else begin
            if (start) begin
                if (next_grant == GNT_CPU) begin
                    op_write   <= avs_write;
                    ram_addr   <= avs_address;
                    ram_byteen <= avs_byteenable;
                    ram_wdata  <= avs_writedata;
                    ram_wren   <= avs_write && cpu_wr_ok;
                end else begin
                    op_write   <= jtag_write;
                    ram_addr   <= jaddr;
                    ram_byteen <= 4'hF;
                    ram_wdata  <= jtag_wdata;
                    ram_wren   <= jtag_write;
                end
            end else begin
                ram_wren <= 1'b0;
            end
            if ((state == RD_WAIT) && (grant == GNT_CPU)) begin
                readdata_q <= ram_rdata;
            end
            if ((state == RD_WAIT) && (grant == GNT_JTAG)) begin
                MonDReg <= ram_rdata;
            end else if (mon_load) begin
                MonDReg <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            end
        end
    end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed self-checking bench for debug_ocimem_arbiter with a behavioural synchronous RAM.
module tb_debug_ocimem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
`ifdef DEBUG_OCIMEM_WRPROT_EN
    logic        debugack;
`endif

    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;

    debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
`ifdef DEBUG_OCIMEM_WRPROT_EN
        .debugack                (debugack),
`endif
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with byte enables and a backdoor preload port.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic strobe_a(input logic [7:0] addr, input logic rden);
        jdo = '0; jdo[25:18] = addr; jdo[17] = rden;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_na();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        jdo = '0; jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("[TB] FAIL rst_mondreg: got %h expected %h", MonDReg, 32'h0); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_readdata: got %h expected %h", avs_readdata, 32'h0); end
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_waitrequest: got %b expected 1", avs_waitrequest); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_wren: got %b expected 0", ram_wren); end
        checks++; if (ram_addr !== 8'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 00", ram_addr); end
        checks++; if (ram_byteen !== 4'h0) begin errors++; $display("[TB] FAIL rst_byteen: got %h expected 0", ram_byteen); end
        checks++; if (ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_wdata: got %h expected 0", ram_wdata); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", jtag_busy); end
        checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_overrun: got %b expected 0", jtag_overrun); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contention();
        strobe_a(8'h30, 1'b1);
        avs_address = 8'h20; avs_read = 1'b1;
        @(negedge clk);
        checks++; if (ram_addr !== 8'h20) begin errors++; $display("[TB] FAIL cont_first_cpu: got %h expected 20", ram_addr); end
        @(negedge clk);
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL cont_cpu_done: got %b expected 0", avs_waitrequest); end
        checks++; if (avs_readdata !== 32'h20202020) begin errors++; $display("[TB] FAIL cont_cpu_data: got %h expected 20202020", avs_readdata); end
        @(posedge clk); #1;
        avs_address = 8'h21;
        @(negedge clk);
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL cont_cpu_wait: got %b expected 1", avs_waitrequest); end
        @(negedge clk);
        checks++; if (ram_addr !== 8'h30) begin errors++; $display("[TB] FAIL cont_jtag_second: got %h expected 30", ram_addr); end
        repeat (2) @(negedge clk);
        checks++; if (MonDReg !== 32'h30303030) begin errors++; $display("[TB] FAIL cont_jtag_data: got %h expected 30303030", MonDReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_jtag_busy: got %b expected 0", jtag_busy); end
        @(negedge clk);
        checks++; if (ram_addr !== 8'h21) begin errors++; $display("[TB] FAIL cont_cpu_third: got %h expected 21", ram_addr); end
        @(negedge clk);
        checks++; if (avs_readdata !== 32'h21212121) begin errors++; $display("[TB] FAIL cont_cpu_data2: got %h expected 21212121", avs_readdata); end
        @(posedge clk); #1;
        avs_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_jtag_read();
        strobe_a(8'h10, 1'b1);
        checks++; if (jtag_busy !== 1'b1) begin errors++; $display("[TB] FAIL jrd_busy_rise: got %b expected 1", jtag_busy); end
        repeat (2) @(negedge clk);
        checks++; if (MonDReg !== 32'h30303030) begin errors++; $display("[TB] FAIL jrd_early: got %h expected 30303030", MonDReg); end
        checks++; if (jtag_busy !== 1'b1) begin errors++; $display("[TB] FAIL jrd_busy_hold: got %b expected 1", jtag_busy); end
        @(negedge clk);
        checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL jrd_data: got %h expected deadbeef", MonDReg); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL jrd_busy_fall: got %b expected 0", jtag_busy); end
        strobe_na();
        repeat (3) @(negedge clk);
        checks++; if (MonDReg !== 32'h11111111) begin errors++; $display("[TB] FAIL jrd_next: got %h expected 11111111", MonDReg); end
    endtask

    task automatic test_jtag_write_wrap();
        strobe_a(8'hFF, 1'b0);
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL jwr_addr_only_busy: got %b expected 0", jtag_busy); end
        strobe_b(32'h1);
        checks++; if (MonDReg !== 32'h1) begin errors++; $display("[TB] FAIL jwr_mondreg_post: got %h expected 1", MonDReg); end
        @(negedge clk);
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("[TB] FAIL jwr_wren: got %b expected 1", ram_wren); end
        checks++; if (ram_addr !== 8'hFF) begin errors++; $display("[TB] FAIL jwr_addr: got %h expected ff", ram_addr); end
        checks++; if (ram_byteen !== 4'hF) begin errors++; $display("[TB] FAIL jwr_byteen: got %h expected f", ram_byteen); end
        @(negedge clk);
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL jwr_wren_end: got %b expected 0", ram_wren); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL jwr_busy_fall: got %b expected 0", jtag_busy); end
        strobe_b(32'h2);
        repeat (2) @(negedge clk);
        checks++; if (mem[8'hFF] !== 32'h1) begin errors++; $display("[TB] FAIL jwr_mem_ff: got %h expected 1", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 32'h2) begin errors++; $display("[TB] FAIL jwr_mem_wrap: got %h expected 2", mem[8'h00]); end
        checks++; if (MonDReg !== 32'h2) begin errors++; $display("[TB] FAIL jwr_mondreg2: got %h expected 2", MonDReg); end
    endtask

    task automatic test_overrun();
        strobe_a(8'h50, 1'b1);
        strobe_b(32'hBAD0BAD0);
        checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", jtag_overrun); end
        repeat (2) @(negedge clk);
        checks++; if (MonDReg !== 32'h50505050) begin errors++; $display("[TB] FAIL ovr_first_only: got %h expected 50505050", MonDReg); end
        repeat (5) @(negedge clk);
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL ovr_no_second: got %b expected 0", jtag_busy); end
        checks++; if (mem[8'h51] !== 32'h0) begin errors++; $display("[TB] FAIL ovr_mem_untouched: got %h expected 0", mem[8'h51]); end
        checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", jtag_overrun); end
    endtask

    task automatic test_reset_mid();
        strobe_a(8'h60, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("[TB] FAIL rmid_mondreg: got %h expected 0", MonDReg); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_readdata: got %h expected 0", avs_readdata); end
        checks++; if (ram_addr !== 8'h0) begin errors++; $display("[TB] FAIL rmid_addr: got %h expected 00", ram_addr); end
        checks++; if (ram_byteen !== 4'h0) begin errors++; $display("[TB] FAIL rmid_byteen: got %h expected 0", ram_byteen); end
        checks++; if (jtag_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", jtag_busy); end
        checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rmid_overrun: got %b expected 0", jtag_overrun); end
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rmid_wait: got %b expected 1", avs_waitrequest); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("[TB] FAIL rmid_discard: got %h expected 0", MonDReg); end
        avs_address = 8'h40; avs_write = 1'b1;
        avs_writedata = 32'hA5A5A5A5; avs_byteenable = 4'b0011;
        @(negedge clk);
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("[TB] FAIL rmid_cpu_wren: got %b expected 1", ram_wren); end
        checks++; if (ram_byteen !== 4'b0011) begin errors++; $display("[TB] FAIL rmid_cpu_byteen: got %b expected 0011", ram_byteen); end
        checks++; if (ram_wdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL rmid_cpu_wdata: got %h expected a5a5a5a5", ram_wdata); end
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL rmid_cpu_done: got %b expected 0", avs_waitrequest); end
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL rmid_wren_pulse: got %b expected 0", ram_wren); end
        checks++; if (mem[8'h40] !== 32'h0000A5A5) begin errors++; $display("[TB] FAIL rmid_mem: got %h expected 0000a5a5", mem[8'h40]); end
    endtask

`ifdef DEBUG_OCIMEM_WRPROT_EN
    task automatic test_wrprot();
        debugack = 1'b0;
        avs_address = 8'h41; avs_write = 1'b1;
        avs_writedata = 32'hFFFFFFFF; avs_byteenable = 4'hF;
        @(negedge clk);
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL wp_done: got %b expected 0", avs_waitrequest); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("[TB] FAIL wp_blocked: got %b expected 0", ram_wren); end
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
        checks++; if (mem[8'h41] !== 32'h0) begin errors++; $display("[TB] FAIL wp_mem41: got %h expected 0", mem[8'h41]); end
        debugack = 1'b1;
        avs_address = 8'h42; avs_write = 1'b1;
        @(negedge clk);
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("[TB] FAIL wp_allowed: got %b expected 1", ram_wren); end
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
        checks++; if (mem[8'h42] !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL wp_mem42: got %h expected ffffffff", mem[8'h42]); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef DEBUG_OCIMEM_WRPROT_EN
        debugack = 1'b1;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h11, 32'h11111111);
        preload(8'h20, 32'h20202020);
        preload(8'h21, 32'h21212121);
        preload(8'h30, 32'h30303030);
        preload(8'h40, 32'h0);
        preload(8'h41, 32'h0);
        preload(8'h42, 32'h0);
        preload(8'h50, 32'h50505050);
        preload(8'h51, 32'h0);
        preload(8'h60, 32'h60606060);
        test_contention();
        test_jtag_read();
        test_jtag_write_wrap();
        test_overrun();
        test_reset_mid();
`ifdef DEBUG_OCIMEM_WRPROT_EN
        test_wrprot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
